axi_mst_bridge: RTL and testbench

Single-outstanding AXI4 initiator converting a simple CPU-style load/store request port into single-beat AXI read or write transactions on the `s_axi_mosi_t` / `s_axi_miso_t` bus. It is the driving end of the bus that our AXI memory and peripheral responders sit on. It is used by testbench traffic generators and by core LSU/fetch paths. It performs lane alignment, write strobe generation, read-data extraction and response-error reporting.

---
 rtl/utils_pkg.sv | 100 ++++++++++
 rtl/axi_mst_lane_align.sv | 34 +++
 rtl/axi_mst_bridge.sv | 198 +++++++++++++++++++
 tb/tb_axi_mst_bridge.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// Shared AXI4 bus types plus the axi_mst_bridge state, request-size and strobe helpers.
// The bridge's optional watchdog is enabled by defining AXI_MST_TIMEOUT_EN.
package utils_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_USER_W = 1;

  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [AXI_STRB_W-1:0] axi_strb_t;
  typedef logic [AXI_ID_W-1:0]   axi_id_t;
  typedef logic [AXI_USER_W-1:0] axi_user_t;
  typedef logic [2:0]            axi_size_t;
  typedef logic [1:0]            axi_resp_t;
  typedef logic [1:0]            axi_burst_t;

  localparam axi_resp_t  AXI_OKAY       = 2'b00;
  localparam axi_resp_t  AXI_EXOKAY     = 2'b01;
  localparam axi_resp_t  AXI_SLVERR     = 2'b10;
  localparam axi_resp_t  AXI_DECERR     = 2'b11;
  localparam axi_burst_t AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    axi_id_t    awid;
    axi_addr_t  awaddr;
    logic [7:0] awlen;
    axi_size_t  awsize;
    axi_burst_t awburst;
    logic       awlock;
    logic [3:0] awcache;
    logic [2:0] awprot;
    logic [3:0] awqos;
    logic [3:0] awregion;
    axi_user_t  awuser;
    logic       awvalid;
    axi_data_t  wdata;
    axi_strb_t  wstrb;
    logic       wlast;
    axi_user_t  wuser;
    logic       wvalid;
    logic       bready;
    axi_id_t    arid;
    axi_addr_t  araddr;
    logic [7:0] arlen;
    axi_size_t  arsize;
    axi_burst_t arburst;
    logic       arlock;
    logic [3:0] arcache;
    logic [2:0] arprot;
    logic [3:0] arqos;
    logic [3:0] arregion;
    axi_user_t  aruser;
    logic       arvalid;
    logic       rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic      awready;
    logic      wready;
    axi_id_t   bid;
    axi_resp_t bresp;
    axi_user_t buser;
    logic      bvalid;
    logic      arready;
    axi_id_t   rid;
    axi_data_t rdata;
    axi_resp_t rresp;
    logic      rlast;
    axi_user_t ruser;
    logic      rvalid;
  } s_axi_miso_t;

  typedef enum logic [2:0] {
    AXI_MST_IDLE,
    AXI_MST_RD_ADDR,
    AXI_MST_RD_DATA,
    AXI_MST_WR_REQ,
    AXI_MST_WR_RESP,
    AXI_MST_RESP
  } axi_mst_st_t;

  typedef enum logic [1:0] {
    REQ_SIZE_BYTE  = 2'd0,
    REQ_SIZE_HALF  = 2'd1,
    REQ_SIZE_WORD  = 2'd2,
    REQ_SIZE_WORD3 = 2'd3
  } req_size_t;

  function automatic axi_strb_t size_to_strb(req_size_t size);
    case (size)
      REQ_SIZE_BYTE: return 4'h1;
      REQ_SIZE_HALF: return 4'h3;
      default:       return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/axi_mst_lane_align.sv
// Byte-lane steering for the AXI initiator: write data/strobe placement and
// read-data extraction, zero-extended to the request size.
module axi_mst_lane_align
  import utils_pkg::*;
(
  input  logic [1:0] offset,
  input  req_size_t  size,
  input  axi_data_t  wdata_in,
  input  axi_data_t  rdata_in,
  output axi_data_t  wdata_out,
  output axi_strb_t  wstrb,
  output axi_data_t  rdata_out
);

  logic [4:0] shift;
  axi_data_t  size_mask;

  assign shift = {offset, 3'b000};

  // NOTE: every variable written in a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    size_mask = '1;
    case (size)
      REQ_SIZE_BYTE: size_mask = 32'h0000_00FF;
      REQ_SIZE_HALF: size_mask = 32'h0000_FFFF;
      default:       size_mask = '1;
    endcase
  end

  assign wdata_out = wdata_in << shift;
  assign wstrb     = size_to_strb(size) << offset;
  assign rdata_out = (rdata_in >> shift) & size_mask;

endmodule

// File: rtl/axi_mst_bridge.sv
// Single-outstanding AXI4 initiator turning load/store requests into single-beat bursts.
// Define AXI_MST_TIMEOUT_EN to add a watchdog that ends a stalled transaction with an error.
module axi_mst_bridge
  import utils_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] AXI_ID         = '0,
  parameter int unsigned         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output s_axi_mosi_t axi_mosi,
  input  s_axi_miso_t axi_miso
);

  axi_mst_st_t state_q, state_d;
  axi_addr_t   addr_q;
  req_size_t   size_q;
  axi_data_t   wdata_q;
  axi_data_t   rdata_q;
  logic        err_q;
  logic        aw_done_q, w_done_q;

  req_size_t   req_size_n;
  logic        misaligned;
  logic        busy;
  logic        timeout_hit;
  logic        ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic        aw_hs, w_hs;
  axi_data_t   lane_wdata, lane_rdata;
  axi_strb_t   lane_wstrb;

  // Size 3 is carried as a plain word from acceptance onwards.
  assign req_size_n = (req_size == 2'd3) ? REQ_SIZE_WORD : req_size_t'(req_size);

  always_comb begin
    misaligned = 1'b0;
    case (req_size_n)
      REQ_SIZE_HALF: misaligned = req_addr[0];
      REQ_SIZE_WORD: misaligned = |req_addr[1:0];
      default:       misaligned = 1'b0;
    endcase
  end

  assign busy = (state_q == AXI_MST_RD_ADDR) || (state_q == AXI_MST_RD_DATA) ||
                (state_q == AXI_MST_WR_REQ)  || (state_q == AXI_MST_WR_RESP);

`ifdef AXI_MST_TIMEOUT_EN
  logic [31:0] timeout_cnt_q;

  assign timeout_hit = busy && (timeout_cnt_q == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst || state_q == AXI_MST_IDLE) begin
      timeout_cnt_q <= '0;
    end else if (busy) begin
      timeout_cnt_q <= timeout_cnt_q + 32'd1;
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!rst && timeout_hit) begin
      $error("axi_mst_bridge: transaction timeout at addr 0x%08h", addr_q);
    end
  end
`endif
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Bus valids/readies decode registered state only, so nothing from axi_miso reaches axi_mosi.
  assign ar_valid = (state_q == AXI_MST_RD_ADDR) && !timeout_hit;
  assign r_ready  = (state_q == AXI_MST_RD_DATA) && !timeout_hit;
  assign aw_valid = (state_q == AXI_MST_WR_REQ) && !aw_done_q && !timeout_hit;
  assign w_valid  = (state_q == AXI_MST_WR_REQ) && !w_done_q && !timeout_hit;
  assign b_ready  = (state_q == AXI_MST_WR_RESP) && !timeout_hit;
  assign aw_hs    = aw_valid && axi_miso.awready;
  assign w_hs     = w_valid && axi_miso.wready;

  axi_mst_lane_align u_lane_align (
    .offset    (addr_q[1:0]),
    .size      (size_q),
    .wdata_in  (wdata_q),
    .rdata_in  (axi_miso.rdata),
    .wdata_out (lane_wdata),
    .wstrb     (lane_wstrb),
    .rdata_out (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      AXI_MST_IDLE: begin
        if (req_valid) begin
          if (misaligned)  state_d = AXI_MST_RESP;
          else if (req_we) state_d = AXI_MST_WR_REQ;
          else             state_d = AXI_MST_RD_ADDR;
        end
      end
      AXI_MST_RD_ADDR: if (axi_miso.arready) state_d = AXI_MST_RD_DATA;
      AXI_MST_RD_DATA: if (axi_miso.rvalid)  state_d = AXI_MST_RESP;
      AXI_MST_WR_REQ: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = AXI_MST_WR_RESP;
      end
      AXI_MST_WR_RESP: if (axi_miso.bvalid) state_d = AXI_MST_RESP;
      AXI_MST_RESP:    if (resp_ready)      state_d = AXI_MST_IDLE;
      default:         state_d = AXI_MST_IDLE;
    endcase
    if (timeout_hit) state_d = AXI_MST_RESP;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= AXI_MST_IDLE;
      addr_q    <= '0;
      size_q    <= REQ_SIZE_BYTE;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        AXI_MST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            size_q    <= req_size_n;
            wdata_q   <= req_wdata;
            rdata_q   <= '0;
            err_q     <= misaligned;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        AXI_MST_RD_DATA: begin
          if (axi_miso.rvalid) begin
            err_q   <= (axi_miso.rresp != AXI_OKAY);
            rdata_q <= (axi_miso.rresp == AXI_OKAY) ? lane_rdata : '0;
          end
        end
        AXI_MST_WR_REQ: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        AXI_MST_WR_RESP: begin
          if (axi_miso.bvalid) err_q <= (axi_miso.bresp != AXI_OKAY);
        end
        default: ;
      endcase
      if (timeout_hit) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  assign req_ready  = (state_q == AXI_MST_IDLE);
  assign resp_valid = (state_q == AXI_MST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    axi_mosi         = '0;
    axi_mosi.awid    = AXI_ID;
    axi_mosi.awaddr  = addr_q;
    axi_mosi.awsize  = {1'b0, size_q};
    axi_mosi.awburst = AXI_BURST_INCR;
    axi_mosi.awvalid = aw_valid;
    axi_mosi.wdata   = lane_wdata;
    axi_mosi.wstrb   = lane_wstrb;
    axi_mosi.wlast   = 1'b1;
    axi_mosi.wvalid  = w_valid;
    axi_mosi.bready  = b_ready;
    axi_mosi.arid    = AXI_ID;
    axi_mosi.araddr  = addr_q;
    axi_mosi.arsize  = {1'b0, size_q};
    axi_mosi.arburst = AXI_BURST_INCR;
    axi_mosi.arvalid = ar_valid;
    axi_mosi.rready  = r_ready;
  end

  logic unused_miso;
  assign unused_miso = ^{axi_miso.bid, axi_miso.buser, axi_miso.rid, axi_miso.rlast, axi_miso.ruser};

endmodule

// File: tb/tb_axi_mst_bridge.sv
// Scoreboard bench for axi_mst_bridge against a small AXI memory responder model.
// With AXI_MST_TIMEOUT_EN defined the watchdog is built with an 8-cycle limit and exercised.
module tb_axi_mst_bridge;
  import utils_pkg::*;

`ifdef AXI_MST_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;

  axi_mst_bridge #(.AXI_ID('0), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_mosi(axi_mosi), .axi_miso(axi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- responder model ----------------
  logic [31:0] mem [logic [29:0]];
  int          aw_stall = 0;
  logic        r_hang = 1'b0;
  axi_resp_t   bresp_k = AXI_OKAY;
  axi_resp_t   rresp_k = AXI_OKAY;
  int          aw_wait;
  logic        got_aw, got_w, bvalid_r, rvalid_r;
  logic [31:0] aw_addr_c, w_data_c, rdata_r;
  logic [3:0]  w_strb_c;
  logic [31:0] last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;
  logic        last_wlast;
  logic [2:0]  last_arsize;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
  endfunction

  always_comb begin
    axi_miso         = '0;
    axi_miso.arready = 1'b1;
    axi_miso.awready = (aw_wait >= aw_stall);
    axi_miso.wready  = 1'b1;
    axi_miso.bvalid  = bvalid_r;
    axi_miso.bresp   = bresp_k;
    axi_miso.rvalid  = rvalid_r;
    axi_miso.rdata   = rdata_r;
    axi_miso.rresp   = rresp_k;
    axi_miso.rlast   = 1'b1;
  end

  always @(posedge clk) begin
    logic        aw_hs, w_hs;
    logic [31:0] a, d, word;
    logic [3:0]  s;
    aw_hs = axi_mosi.awvalid && axi_miso.awready;
    w_hs  = axi_mosi.wvalid && axi_miso.wready;
    if (rst) begin
      aw_wait <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0; rdata_r <= '0;
    end else begin
      if (axi_mosi.awvalid && !axi_miso.awready) aw_wait <= aw_wait + 1;
      if (aw_hs) begin
        aw_wait <= 0; got_aw <= 1'b1; aw_addr_c <= axi_mosi.awaddr; last_awaddr <= axi_mosi.awaddr;
      end
      if (w_hs) begin
        got_w <= 1'b1; w_data_c <= axi_mosi.wdata; w_strb_c <= axi_mosi.wstrb;
        last_wdata <= axi_mosi.wdata; last_wstrb <= axi_mosi.wstrb; last_wlast <= axi_mosi.wlast;
      end
      if ((got_aw || aw_hs) && (got_w || w_hs) && !bvalid_r) begin
        a = aw_hs ? axi_mosi.awaddr : aw_addr_c;
        d = w_hs ? axi_mosi.wdata : w_data_c;
        s = w_hs ? axi_mosi.wstrb : w_strb_c;
        word = mem_rd(a);
        for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
        mem[a[31:2]] = word;
        bvalid_r <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (bvalid_r && axi_mosi.bready) bvalid_r <= 1'b0;
      if (axi_mosi.arvalid && axi_miso.arready) begin
        last_arsize <= axi_mosi.arsize;
        if (!r_hang) begin
          rvalid_r <= 1'b1; rdata_r <= mem_rd(axi_mosi.araddr);
        end
      end
      if (rvalid_r && axi_mosi.rready) rvalid_r <= 1'b0;
    end
  end

  // ---------------- bus activity monitor ----------------
  int ar_cyc = 0, aw_cyc = 0, w_cyc = 0, order_bad = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (axi_mosi.wvalid && !axi_mosi.awvalid && aw_cyc == 0) order_bad++;
      if (axi_mosi.arvalid) ar_cyc++;
      if (axi_mosi.awvalid) aw_cyc++;
      if (axi_mosi.wvalid)  w_cyc++;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t_acc;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  logic resp_seen = 1'b0;
  int   last_acc = 0;

  always @(negedge clk) begin
    if (rst) begin
      resp_seen = 1'b0;
    end else if (resp_valid) begin
      if (!resp_seen) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          check("resp_rdata", resp_rdata, cur.rdata);
          check("resp_err", {31'b0, resp_err}, {31'b0, cur.err});
          if (cur.lat >= 0) check("resp_latency", cycle - cur.t_acc, cur.lat);
        end
        resp_seen = 1'b1;
      end else begin
        check("hold_rdata", resp_rdata, cur.rdata);
        check("hold_err", {31'b0, resp_err}, {31'b0, cur.err});
      end
      if (resp_ready) resp_seen = 1'b0;
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    exp_t e;
    bit   ok;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("req_accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    last_acc = cycle;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.t_acc = cycle;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("drain_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic clr_mon();
    @(negedge clk);
    ar_cyc = 0; aw_cyc = 0; w_cyc = 0; order_bad = 0;
  endtask

  initial begin
    int a1, a2;
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int a1, a2;
    mem[30'h0] = 32'h1234_5678;
    mem[30'h4] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_bus_valids", {27'b0, axi_mosi.arvalid, axi_mosi.rready, axi_mosi.awvalid,
                             axi_mosi.wvalid, axi_mosi.bready}, 32'd0);
    rst = 1'b0;

    // Aligned word read with zero-wait responder.
    clr_mon();
    do_req(1'b0, 32'h10, 2'd2, '0, 32'hDEAD_BEEF, 1'b0, 3);
    wait_idle();
    check("rd_word_ar_cycles", ar_cyc, 32'd1);

    // Byte write to the top lane, then read it back.
    clr_mon();
    do_req(1'b1, 32'h13, 2'd0, 32'h0000_00A5, 32'h0, 1'b0, 3);
    wait_idle();
    check("wb_awaddr", last_awaddr, 32'h13);
    check("wb_wdata", last_wdata, 32'hA500_0000);
    check("wb_wstrb", {28'b0, last_wstrb}, 32'h8);
    check("wb_wlast", {31'b0, last_wlast}, 32'd1);
    check("wb_order", order_bad, 32'd0);
    do_req(1'b0, 32'h13, 2'd0, '0, 32'h0000_00A5, 1'b0, 3);
    do_req(1'b0, 32'h10, 2'd2, '0, 32'hA5AD_BEEF, 1'b0, 3);
    wait_idle();

    // Sub-word reads from word 0.
    do_req(1'b0, 32'h2, 2'd1, '0, 32'h0000_1234, 1'b0, 3);
    do_req(1'b0, 32'h1, 2'd0, '0, 32'h0000_0056, 1'b0, 3);
    wait_idle();

    // Half write at offset 2 drops the upper input bits; byte write at offset 0 keeps only lane 0.
    do_req(1'b1, 32'h6, 2'd1, 32'h1234_BEEF, 32'h0, 1'b0, 3);
    wait_idle();
    check("wh_wdata", last_wdata, 32'hBEEF_0000);
    check("wh_wstrb", {28'b0, last_wstrb}, 32'hC);
    do_req(1'b1, 32'h8, 2'd0, 32'hFFFF_FF11, 32'h0, 1'b0, 3);
    wait_idle();
    check("wb0_wstrb", {28'b0, last_wstrb}, 32'h1);
    do_req(1'b0, 32'h4, 2'd2, '0, 32'hBEEF_0000, 1'b0, 3);
    do_req(1'b0, 32'h6, 2'd1, '0, 32'h0000_BEEF, 1'b0, 3);
    do_req(1'b0, 32'h8, 2'd2, '0, 32'h0000_0011, 1'b0, 3);
    wait_idle();

    // Misaligned accesses never reach the bus.
    clr_mon();
    do_req(1'b0, 32'h6, 2'd2, '0, 32'h0, 1'b1, 1);
    do_req(1'b1, 32'h3, 2'd1, 32'hFFFF, 32'h0, 1'b1, 1);
    wait_idle();
    check("mis_ar_cycles", ar_cyc, 32'd0);
    check("mis_aw_cycles", aw_cyc, 32'd0);

    // AW stalled three cycles while W is taken at once; SLVERR response.
    clr_mon();
    aw_stall = 3; bresp_k = AXI_SLVERR;
    do_req(1'b1, 32'h20, 2'd2, 32'h55AA_55AA, 32'h0, 1'b1, 6);
    wait_idle();
    aw_stall = 0; bresp_k = AXI_OKAY;
    check("stall_aw_cycles", aw_cyc, 32'd4);
    check("stall_w_cycles", w_cyc, 32'd1);
    check("stall_order", order_bad, 32'd0);

    // Read error response returns zero data.
    rresp_k = AXI_DECERR;
    do_req(1'b0, 32'h10, 2'd2, '0, 32'h0, 1'b1, 3);
    wait_idle();
    rresp_k = AXI_OKAY;

    // Size 3 behaves as a word.
    do_req(1'b0, 32'h10, 2'd3, '0, 32'hA5AD_BEEF, 1'b0, 3);
    wait_idle();
    check("size3_arsize", {29'b0, last_arsize}, 32'd2);

    // Back-to-back reads: next accept four cycles after the previous one.
    do_req(1'b0, 32'h0, 2'd2, '0, 32'h1234_5678, 1'b0, 3);
    a1 = last_acc;
    do_req(1'b0, 32'h10, 2'd2, '0, 32'hA5AD_BEEF, 1'b0, 3);
    a2 = last_acc;
    wait_idle();
    check("b2b_gap", a2 - a1, 32'd4);

    // Response held stable while resp_ready is low.
    resp_ready = 1'b0;
    do_req(1'b0, 32'h2, 2'd1, '0, 32'h0000_1234, 1'b0, 3);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (resp_valid) begin ok = 1'b1; break; end
      end
      if (!ok) check("hold_resp_timeout", 32'd0, 32'd1);
    end
    repeat (3) @(negedge clk);
    resp_ready = 1'b1;
    wait_idle();

    // Reset mid-transaction abandons the read within one cycle.
    r_hang = 1'b1;
    do_req(1'b0, 32'h10, 2'd2, '0, 32'h0, 1'b0, -1);
    repeat (3) @(negedge clk);
    check("midrst_rready_before", {31'b0, axi_mosi.rready}, 32'd1);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_rready", {31'b0, axi_mosi.rready}, 32'd0);
    check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    rst = 1'b0;
    r_hang = 1'b0;
    do_req(1'b0, 32'h13, 2'd0, '0, 32'h0000_00A5, 1'b0, 3);
    wait_idle();

`ifdef AXI_MST_TIMEOUT_EN
    // Watchdog: responder never returns read data.
    r_hang = 1'b1;
    do_req(1'b0, 32'h10, 2'd2, '0, 32'h0, 1'b1, 10);
    wait_idle();
    r_hang = 1'b0;
    check("to_rready_after", {31'b0, axi_mosi.rready}, 32'd0);
    do_req(1'b0, 32'h0, 2'd2, '0, 32'h1234_5678, 1'b0, 3);
    wait_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
